// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared constants, types and helpers for the fetch controller
package if_pkg;

  localparam logic [31:0] NOP_WORD = 32'hC800_0000;
  localparam logic [6:0]  OP_B     = 7'b1100000;
  localparam logic [6:0]  OP_BR    = 7'b1100010;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    DRAIN,
    HOLD,
    BRWAIT
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
  } skid_t;

  function automatic logic [31:0] sext16to32(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/if_skid.sv
// rtl/if_skid.sv - single-entry holding register for a response that arrived during stall
module if_skid
  import if_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  clear,
  input  skid_t d,
  output skid_t q,
  output logic  full
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= '0;
      full <= 1'b0;
    end else if (load) begin
      q    <= d;
      full <= 1'b1;
    end else if (clear) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/if_ctrl.sv
// rtl/if_ctrl.sv - fetch sequencer: owns the PC, drives imem requests, feeds ID
module if_ctrl
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        bcond,
  input  logic [15:0] brel,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic [31:0] pc_out
);

  state_t      state, state_d;
  logic [31:0] pc, pc_d;
  logic [31:0] tgt, tgt_d;
  logic [31:0] instr_d, pcout_d;
  logic        valid_d;

  skid_t       skid_q;
  logic        skid_full;
  logic        skid_load, skid_clear;

  logic        redir;
  logic [31:0] redir_pc;
  logic [31:0] pres_instr, pres_addr, b_target;
  logic        is_b, is_br, present;

  if_skid u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (skid_clear),
    .d     ('{addr: pc, instr: imem_rdata}),
    .q     (skid_q),
    .full  (skid_full)
  );

  assign redir    = br_valid | bcond;
  assign redir_pc = br_valid ? (br_target & ~32'h3)
                             : pc_out + (sext16to32(brel) << 2);

  // HOLD presents the skid entry; REQ presents the live memory response
  assign pres_instr = (state == HOLD) ? skid_q.instr : imem_rdata;
  assign pres_addr  = (state == HOLD) ? skid_q.addr  : pc;
  assign is_b       = (pres_instr[31:25] == OP_B);
  assign is_br      = (pres_instr[31:25] == OP_BR);
  assign b_target   = pres_addr + (sext16to32(pres_instr[15:0]) << 2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      tgt         <= RESET_PC;
      instr_out   <= NOP_WORD;
      instr_valid <= 1'b0;
      pc_out      <= 32'h0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      tgt         <= tgt_d;
      instr_out   <= instr_d;
      instr_valid <= valid_d;
      pc_out      <= pcout_d;
    end
  end

  always_comb begin
    state_d    = state;
    pc_d       = pc;
    tgt_d      = tgt;
    instr_d    = instr_out;
    valid_d    = instr_valid;
    pcout_d    = pc_out;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    present    = 1'b0;

    // ID gets a bubble whenever it can advance and nothing new is presented
    if (!stall || redir) begin
      instr_d = NOP_WORD;
      valid_d = 1'b0;
    end
    if (redir) skid_clear = 1'b1;

    case (state)
      IDLE: begin
        state_d = REQ;
        if (redir) pc_d = redir_pc;
      end
      REQ: begin
        if (redir) begin
          if (imem_ready) begin
            pc_d = redir_pc;
          end else begin
            state_d = DRAIN;
            tgt_d   = redir_pc;
          end
        end else if (imem_ready) begin
          if (stall) begin
            skid_load = 1'b1;
            state_d   = HOLD;
          end else begin
            present = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (redir) tgt_d = redir_pc;
        if (imem_ready) begin
          state_d = REQ;
          pc_d    = redir ? redir_pc : tgt;
        end
      end
      HOLD: begin
        if (redir) begin
          state_d = REQ;
          pc_d    = redir_pc;
        end else if (!stall && skid_full) begin
          present    = 1'b1;
          skid_clear = 1'b1;
        end
      end
      BRWAIT: begin
        if (redir) begin
          state_d = REQ;
          pc_d    = redir_pc;
        end
      end
      default: state_d = IDLE;
    endcase

    if (present) begin
      if (is_b) begin
        pc_d    = b_target;
        state_d = REQ;
      end else if (is_br) begin
        pc_d    = pres_addr;
        state_d = BRWAIT;
      end else begin
        instr_d = pres_instr;
        valid_d = 1'b1;
        pcout_d = pres_addr;
        pc_d    = pres_addr + 32'd4;
        state_d = REQ;
      end
    end
  end

  // DRAIN keeps pc untouched, so the outstanding address stays on the bus
  always_comb begin
    imem_req  = (state == REQ) || (state == DRAIN);
    imem_addr = pc;
  end

endmodule

// File: tb/tb_if_ctrl.sv
// tb/tb_if_ctrl.sv - scoreboard bench for if_ctrl
module tb_if_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        bcond;
  logic [15:0] brel;
  logic        br_valid;
  logic [31:0] br_target;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic [31:0] pc_out;

  logic        ready_en;
  logic        stall_s, rst_s;
  int          n_tests, n_fail;
  logic [31:0] exp_fetch[$];
  logic [63:0] exp_out[$];

  if_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .imem_addr   (imem_addr),
    .imem_req    (imem_req),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .bcond       (bcond),
    .brel        (brel),
    .br_valid    (br_valid),
    .br_target   (br_target),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .pc_out      (pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0010: return 32'hC000_FFFE;
      32'h0000_0060: return 32'hC400_0000;
      default:       return 32'h0200_0000 | a;
    endcase
  endfunction

  assign imem_rdata = mem_word(imem_addr);
  assign imem_ready = imem_req & ready_en;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    stall_s <= stall;
    rst_s   <= rst;
  end

  always @(negedge clk) begin
    if (imem_req && imem_ready) begin
      if (exp_fetch.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL fetch_unexpected: got addr %h expected none", imem_addr);
      end else begin
        check32("fetch_addr", imem_addr, exp_fetch.pop_front());
      end
    end
    if (instr_valid && !stall_s && !rst_s) begin
      if (exp_out.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL out_unexpected: got %h@%h expected none", instr_out, pc_out);
      end else begin
        logic [63:0] e;
        e = exp_out.pop_front();
        check32("out_instr", instr_out, e[63:32]);
        check32("out_pc", pc_out, e[31:0]);
      end
    end
  end

  task automatic start(input logic [31:0] target);
    rst = 1'b1;
    step();
    rst       = 1'b0;
    br_valid  = 1'b1;
    br_target = target;
    step();
    br_valid  = 1'b0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b1; ready_en = 1'b0; stall = 1'b0; bcond = 1'b0;
    brel = 16'h0; br_valid = 1'b0; br_target = 32'h0;
    step(); step();
    check32("rst_req", {31'b0, imem_req}, 32'h0);
    check32("rst_instr", instr_out, 32'hC800_0000);
    check32("rst_valid", {31'b0, instr_valid}, 32'h0);
    check32("rst_pc_out", pc_out, 32'h0);

    // sequential fetch at full throughput
    exp_fetch.push_back(32'h0); exp_fetch.push_back(32'h4); exp_fetch.push_back(32'h8);
    exp_out.push_back({32'h0200_0000, 32'h0});
    exp_out.push_back({32'h0200_0004, 32'h4});
    exp_out.push_back({32'h0200_0008, 32'h8});
    rst = 1'b0; ready_en = 1'b1;
    repeat (4) step();
    ready_en = 1'b0;

    // local B at 0x10 with offset -2 lands on 0x08
    exp_fetch.push_back(32'h10); exp_fetch.push_back(32'h08);
    exp_out.push_back({32'h0200_0008, 32'h8});
    start(32'h10);
    ready_en = 1'b1;
    step();
    check32("b_instr", instr_out, 32'hC800_0000);
    check32("b_valid", {31'b0, instr_valid}, 32'h0);
    check32("b_addr", imem_addr, 32'h08);
    step();
    ready_en = 1'b0;

    // bcond +3 words from pc_out 0x20
    exp_fetch.push_back(32'h20); exp_fetch.push_back(32'h24); exp_fetch.push_back(32'h2C);
    exp_out.push_back({32'h0200_0020, 32'h20});
    exp_out.push_back({32'h0200_002C, 32'h2C});
    start(32'h20);
    ready_en = 1'b1;
    step();
    bcond = 1'b1; brel = 16'h0003;
    step();
    bcond = 1'b0;
    check32("bc_instr", instr_out, 32'hC800_0000);
    check32("bc_valid", {31'b0, instr_valid}, 32'h0);
    check32("bc_addr", imem_addr, 32'h2C);
    step();
    ready_en = 1'b0;

    // br_valid while the fetch at 0x40 is outstanding
    exp_fetch.push_back(32'h40); exp_fetch.push_back(32'h100);
    exp_out.push_back({32'h0200_0100, 32'h100});
    start(32'h40);
    br_valid = 1'b1; br_target = 32'h103;
    step();
    br_valid = 1'b0;
    check32("drain_addr1", imem_addr, 32'h40);
    check32("drain_req", {31'b0, imem_req}, 32'h1);
    step();
    check32("drain_addr2", imem_addr, 32'h40);
    ready_en = 1'b1;
    step();
    check32("drain_new_addr", imem_addr, 32'h100);
    check32("drain_dropped", {31'b0, instr_valid}, 32'h0);
    step();
    ready_en = 1'b0;

    // stall captures 0x50 into the skid
    exp_fetch.push_back(32'h4C); exp_fetch.push_back(32'h50);
    exp_out.push_back({32'h0200_004C, 32'h4C});
    exp_out.push_back({32'h0200_0050, 32'h50});
    start(32'h4C);
    ready_en = 1'b1;
    step();
    stall = 1'b1;
    step();
    check32("skid_hold_instr", instr_out, 32'h0200_004C);
    check32("skid_hold_pc", pc_out, 32'h4C);
    check32("skid_req", {31'b0, imem_req}, 32'h0);
    step();
    check32("skid_req2", {31'b0, imem_req}, 32'h0);
    check32("skid_hold_instr2", instr_out, 32'h0200_004C);
    stall = 1'b0; ready_en = 1'b0;
    step();
    check32("skid_next_addr", imem_addr, 32'h54);

    // BR waits for br_valid; br_valid beats a simultaneous bcond
    exp_fetch.push_back(32'h60);
    start(32'h60);
    ready_en = 1'b1;
    step();
    ready_en = 1'b0;
    check32("br_instr", instr_out, 32'hC800_0000);
    check32("br_valid_out", {31'b0, instr_valid}, 32'h0);
    check32("br_req", {31'b0, imem_req}, 32'h0);
    step();
    check32("br_req2", {31'b0, imem_req}, 32'h0);
    br_valid = 1'b1; br_target = 32'h200; bcond = 1'b1; brel = 16'h0010;
    step();
    br_valid = 1'b0; bcond = 1'b0;
    check32("br_addr", imem_addr, 32'h200);
    check32("br_req3", {31'b0, imem_req}, 32'h1);

    step(); step();
    check32("fetch_q_empty", exp_fetch.size(), 32'h0);
    check32("out_q_empty", exp_out.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
